// File: rtl/rsa_modexp_if.sv
// Operand/result bus for rsa_modexp_core: one request channel (operands) and
// one response channel (result + error flag).
interface rsa_modexp_if #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH,
  parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
);
  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; the sender keeps valid and payload
  // stable until that edge, and ready never depends combinationally on valid.
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH-1:0]     i_a;
  logic [EXP_WIDTH-1:0] i_d;
  logic [LEN_W-1:0]     i_d_len;
  logic [WIDTH-1:0]     i_n;

  logic                 o_valid;
  logic                 i_ready;
  logic [WIDTH-1:0]     o_result;
  logic                 o_err;

  modport slave (
    input  i_valid, i_a, i_d, i_d_len, i_n, i_ready,
    output o_ready, o_valid, o_result, o_err
  );

  modport master (
    output i_valid, i_a, i_d, i_d_len, i_n, i_ready,
    input  o_ready, o_valid, o_result, o_err
  );
endinterface

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation a^d mod n: right-to-left binary method with two
// bit-serial Montgomery units (square and multiply) stepping in parallel.
module rsa_modexp_core #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH,
  parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  rsa_modexp_if.slave bus,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MONT = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]     n_r;
  logic [WIDTH-1:0]     t_r;       // a^(2^k) in the Montgomery domain
  logic [WIDTH-1:0]     m_r;       // running product, plain domain
  logic [WIDTH-1:0]     x_r;       // serial multiplier bits of t, LSB first
  logic [EXP_WIDTH-1:0] d_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     k_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH:0]       acc_s_r;
  logic [WIDTH:0]       acc_m_r;
  logic [WIDTH-1:0]     result_r;
  logic                 err_r;

  logic                 accept;
  logic                 op_err;
  logic                 cnt_last;
  logic [CNT_W-1:0]     cnt_nx;
  logic [WIDTH:0]       prep_dbl;
  logic [WIDTH:0]       prep_sub;
  logic [WIDTH-1:0]     prep_nx;
  logic [WIDTH:0]       mont_s;
  logic [WIDTH:0]       mont_m;
  logic [LEN_W-1:0]     k_nx;
  logic [WIDTH-1:0]     upd_m;

  // One Montgomery step on a WIDTH+2-bit sum; the stored accumulator stays
  // below 2n so WIDTH+1 bits hold it. The final step folds it below n.
  function automatic logic [WIDTH:0] mont_step(
    input logic [WIDTH:0]   acc,
    input logic             xb,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] n,
    input logic             last
  );
    logic [WIDTH+1:0] s;
    logic [WIDTH:0]   sh;
    s = {1'b0, acc} + (xb ? {2'b00, y} : '0);
    if (s[0]) s = s + {2'b00, n};
    sh = s[WIDTH+1:1];
    if (last && (sh >= {1'b0, n})) sh = sh - {1'b0, n};
    return sh;
  endfunction

  assign accept   = bus.i_valid && (state == S_IDLE);
  assign op_err   = !bus.i_n[0] || (bus.i_n == WIDTH'(1)) || (bus.i_a >= bus.i_n) ||
                    (bus.i_d_len > LEN_W'(EXP_WIDTH));
  assign cnt_last = (cnt_r == CNT_W'(WIDTH - 1));
  assign cnt_nx   = cnt_last ? '0 : cnt_r + CNT_W'(1);

  assign prep_dbl = {t_r, 1'b0};
  assign prep_sub = prep_dbl - {1'b0, n_r};
  assign prep_nx  = (prep_dbl >= {1'b0, n_r}) ? prep_sub[WIDTH-1:0] : prep_dbl[WIDTH-1:0];

  assign mont_s = mont_step(acc_s_r, x_r[0], t_r, n_r, cnt_last);
  assign mont_m = mont_step(acc_m_r, x_r[0], m_r, n_r, cnt_last);

  assign k_nx  = k_r + LEN_W'(1);
  assign upd_m = d_r[0] ? acc_m_r[WIDTH-1:0] : m_r;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    o_busy      = 1'b1;
    case (state)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        o_busy      = 1'b0;
        if (accept) begin
          if (op_err || (bus.i_d_len == '0)) state_nx = S_DONE;
          else                               state_nx = S_PREP;
        end
      end
      S_PREP: if (cnt_last) state_nx = S_MONT;
      S_MONT: if (cnt_last) state_nx = S_UPD;
      S_UPD:  state_nx = (k_nx == len_r) ? S_DONE : S_MONT;
      S_DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_r      <= '0;
      t_r      <= '0;
      m_r      <= '0;
      x_r      <= '0;
      d_r      <= '0;
      len_r    <= '0;
      k_r      <= '0;
      cnt_r    <= '0;
      acc_s_r  <= '0;
      acc_m_r  <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            n_r      <= bus.i_n;
            d_r      <= bus.i_d;
            len_r    <= bus.i_d_len;
            t_r      <= bus.i_a;
            m_r      <= WIDTH'(1);
            k_r      <= '0;
            cnt_r    <= '0;
            err_r    <= op_err;
            result_r <= (!op_err && (bus.i_d_len == '0)) ? WIDTH'(1) : '0;
          end
        end
        S_PREP: begin
          t_r   <= prep_nx;
          cnt_r <= cnt_nx;
          if (cnt_last) begin
            x_r     <= prep_nx;
            acc_s_r <= '0;
            acc_m_r <= '0;
          end
        end
        S_MONT: begin
          x_r     <= x_r >> 1;
          acc_s_r <= mont_s;
          acc_m_r <= mont_m;
          cnt_r   <= cnt_nx;
        end
        S_UPD: begin
          // The exponent is consumed LSB first, so d_r[0] is always bit k.
          t_r     <= acc_s_r[WIDTH-1:0];
          x_r     <= acc_s_r[WIDTH-1:0];
          m_r     <= upd_m;
          d_r     <= d_r >> 1;
          k_r     <= k_nx;
          acc_s_r <= '0;
          acc_m_r <= '0;
          if (k_nx == len_r) result_r <= upd_m;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_result = result_r;
  assign bus.o_err    = err_r;
  assign o_dbg_state  = state;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and random jobs on 8-, 16- and 256-bit cores against a wide-arithmetic
// square-and-multiply reference.
module tb_rsa_modexp_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rsa_modexp_if #(.WIDTH(8),   .EXP_WIDTH(8),   .LEN_W(4)) bus8 ();
  rsa_modexp_if #(.WIDTH(16),  .EXP_WIDTH(16),  .LEN_W(5)) bus16 ();
  rsa_modexp_if #(.WIDTH(256), .EXP_WIDTH(256), .LEN_W(9)) bus256 ();

  logic       busy8, busy16, busy256;
  logic [2:0] st8, st16, st256;

  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8), .LEN_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(bus8), .o_busy(busy8), .o_dbg_state(st8));
  rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16), .LEN_W(5)) dut16 (
    .i_clk(clk), .i_rst(rst), .bus(bus16), .o_busy(busy16), .o_dbg_state(st16));
  rsa_modexp_core #(.WIDTH(256), .EXP_WIDTH(256), .LEN_W(9)) dut256 (
    .i_clk(clk), .i_rst(rst), .bus(bus256), .o_busy(busy256), .o_dbg_state(st256));

  function automatic logic [511:0] ref_modexp(input logic [511:0] a, input logic [511:0] d,
                                              input int len, input logic [511:0] n);
    logic [511:0] r, b;
    r = 1;
    b = a % n;
    for (int i = 0; i < len; i++) begin
      if (d[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [511:0] a, input logic [511:0] n,
                                   input int len, input int expw);
    return (n[0] == 1'b0) || (n == 1) || (a >= n) || (len > expw);
  endfunction

  function automatic logic [511:0] rand256();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; the caller's negedge is the accept cycle.
  task automatic job8(input string tag, input logic [511:0] a, input logic [511:0] d,
                      input int len, input logic [511:0] n, input logic [511:0] exp_res,
                      input logic exp_err, input int hold);
    int lat, exp_lat;
    exp_lat = (exp_err || len == 0) ? 1 : 1 + 8 + len * 9;
    check({tag, ".ready"}, bus8.o_ready, 1);
    bus8.i_a = a[7:0]; bus8.i_d = d[7:0]; bus8.i_d_len = 4'(len); bus8.i_n = n[7:0];
    bus8.i_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.i_valid = 1'b0;
    lat = 1;
    while (!bus8.o_valid && lat < exp_lat + 20) begin @(negedge clk); lat++; end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, bus8.o_result, exp_res);
    check({tag, ".err"}, bus8.o_err, exp_err);
    check({tag, ".busy"}, busy8, 1);
    for (int i = 0; i < hold; i++) begin
      bus8.i_valid = 1'b1;
      bus8.i_a = 8'($urandom); bus8.i_n = 8'($urandom); bus8.i_d_len = 4'($urandom_range(0, 8));
      @(negedge clk);
      check({tag, ".hold_valid"}, bus8.o_valid, 1);
      check({tag, ".hold_result"}, bus8.o_result, exp_res);
      check({tag, ".hold_ready"}, bus8.o_ready, 0);
    end
    bus8.i_valid = 1'b0;
    bus8.i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.i_ready = 1'b0;
    check({tag, ".drop_valid"}, bus8.o_valid, 0);
    check({tag, ".idle_ready"}, bus8.o_ready, 1);
  endtask

  task automatic job16(input string tag, input logic [511:0] a, input logic [511:0] d,
                       input int len, input logic [511:0] n, input logic [511:0] exp_res,
                       input logic exp_err);
    int lat, exp_lat;
    exp_lat = (exp_err || len == 0) ? 1 : 1 + 16 + len * 17;
    check({tag, ".ready"}, bus16.o_ready, 1);
    bus16.i_a = a[15:0]; bus16.i_d = d[15:0]; bus16.i_d_len = 5'(len); bus16.i_n = n[15:0];
    bus16.i_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.i_valid = 1'b0;
    lat = 1;
    while (!bus16.o_valid && lat < exp_lat + 20) begin @(negedge clk); lat++; end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, bus16.o_result, exp_res);
    check({tag, ".err"}, bus16.o_err, exp_err);
    bus16.i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.i_ready = 1'b0;
    check({tag, ".drop_valid"}, bus16.o_valid, 0);
  endtask

  task automatic job256(input string tag, input logic [511:0] a, input logic [511:0] d,
                        input int len, input logic [511:0] n, input logic [511:0] exp_res,
                        input logic exp_err);
    int lat, exp_lat;
    exp_lat = (exp_err || len == 0) ? 1 : 1 + 256 + len * 257;
    check({tag, ".ready"}, bus256.o_ready, 1);
    bus256.i_a = a[255:0]; bus256.i_d = d[255:0]; bus256.i_d_len = 9'(len);
    bus256.i_n = n[255:0];
    bus256.i_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus256.i_valid = 1'b0;
    lat = 1;
    while (!bus256.o_valid && lat < exp_lat + 20) begin @(negedge clk); lat++; end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, bus256.o_result, exp_res);
    check({tag, ".err"}, bus256.o_err, exp_err);
    bus256.i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus256.i_ready = 1'b0;
    check({tag, ".drop_valid"}, bus256.o_valid, 0);
  endtask

  initial begin
    logic [511:0] ra, rd, rn;
    int           rl, seen;

    bus8.i_valid = 0;   bus8.i_ready = 0;   bus8.i_a = 0;   bus8.i_d = 0;
    bus8.i_d_len = 0;   bus8.i_n = 0;
    bus16.i_valid = 0;  bus16.i_ready = 0;  bus16.i_a = 0;  bus16.i_d = 0;
    bus16.i_d_len = 0;  bus16.i_n = 0;
    bus256.i_valid = 0; bus256.i_ready = 0; bus256.i_a = 0; bus256.i_d = 0;
    bus256.i_d_len = 0; bus256.i_n = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready8", bus8.o_ready, 1);
    check("rst.valid8", bus8.o_valid, 0);
    check("rst.result8", bus8.o_result, 0);
    check("rst.err8", bus8.o_err, 0);
    check("rst.busy8", busy8, 0);
    check("rst.valid16", bus16.o_valid, 0);
    check("rst.busy256", busy256, 0);

    // Directed cases
    job8("w8_basic", 5, 3, 2, 33, 26, 0, 0);
    job16("w16_basic", 4, 13, 4, 497, 445, 0);
    job16("w16_upper_ignored", 4, 16'h800D, 4, 497, 445, 0);
    job8("w8_even_n", 5, 3, 2, 34, 0, 1, 0);
    job8("w8_a_ge_n", 40, 3, 2, 33, 0, 1, 0);
    job8("w8_n_one", 0, 3, 2, 1, 0, 1, 0);
    job8("w8_len_too_big", 5, 3, 9, 33, 0, 1, 0);
    job8("w8_len0_hold", 7, 8'hA5, 0, 33, 1, 0, 10);
    job8("w8_full_len", 2, 8'hFF, 8, 33, ref_modexp(2, 8'hFF, 8, 33), 0, 0);

    // Reset in the middle of a job
    check("rstmid.ready", bus8.o_ready, 1);
    bus8.i_a = 5; bus8.i_d = 3; bus8.i_d_len = 2; bus8.i_n = 33; bus8.i_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.i_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("rstmid.busy_before", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", busy8, 0);
    check("rstmid.ready", bus8.o_ready, 1);
    check("rstmid.valid", bus8.o_valid, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus8.o_valid) seen++;
    end
    check("rstmid.no_valid", seen, 0);
    job8("w8_after_rst", 2, 10, 4, 33, 1, 0, 0);

    // Random 8- and 16-bit jobs
    for (int i = 0; i < 8; i++) begin
      rn = $urandom_range(1, 127) * 2 + 1;
      ra = $urandom_range(0, int'(rn[31:0]) - 1);
      rd = $urandom_range(0, 255);
      rl = $urandom_range(0, 8);
      job8("w8_rand", ra, rd, rl, rn, ref_modexp(ra, rd, rl, rn), ref_err(ra, rn, rl, 8), 0);
    end
    for (int i = 0; i < 4; i++) begin
      rn = $urandom_range(1, 32767) * 2 + 1;
      ra = $urandom_range(0, int'(rn[31:0]) - 1);
      rd = $urandom_range(0, 65535);
      rl = $urandom_range(1, 16);
      job16("w16_rand", ra, rd, rl, rn, ref_modexp(ra, rd, rl, rn), ref_err(ra, rn, rl, 16));
    end

    // Full-width jobs, the second accepted right after the first handshake
    rn = rand256();
    rn[255] = 1'b1; rn[0] = 1'b1;
    ra = rand256() % rn;
    rd = rand256();
    job256("w256_full", ra, rd, 256, rn, ref_modexp(ra, rd, 256, rn), 0);
    rn = rand256();
    rn[255] = 1'b1; rn[0] = 1'b1;
    ra = rand256() % rn;
    rd = rand256();
    job256("w256_b2b", ra, rd, 16, rn, ref_modexp(ra, rd, 16, rn), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
- Parametrised successor to the fixed 256-bit RSA decryption core. Computes o_result = i_a^i_d mod i_n using right-to-left binary exponentiation.
- Operand preparation: modular doubling maps i_a into the Montgomery domain. Two bit-serial Montgomery multipliers then run in parallel, one for square and one for multiply.
- Adds what the fixed core lacks:
  - width parameter
  - valid/ready handshakes on both sides
  - runtime exponent length, so short exponents finish early
  - operand error detection
- Sits between the host-side operand registers and the result readback path.

Parameters:
- WIDTH, 256, modulus/operand width in bits (≥ 4).
- EXP_WIDTH, WIDTH, maximum exponent width in bits.
- LEN_W, $clog2(EXP_WIDTH+1), width of the exponent-length input.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  operand set valid.
- o_ready  out  1  core can accept an operand set (high only in IDLE).
- i_a  in  WIDTH  base (ciphertext); must be < i_n.
- i_d  in  EXP_WIDTH  exponent; bits at index ≥ i_d_len are ignored.
- i_d_len  in  LEN_W  number of exponent bits to process (0..EXP_WIDTH).
- i_n  in  WIDTH  modulus; must be odd and > 1.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  downstream accepts the result.
- o_result  out  WIDTH  a^d mod n; 0 when o_err = 1.
- o_err  out  1  operand error flag; qualified by o_valid.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - State goes to IDLE; all counters and data registers clear.
  - o_ready = 1, o_valid = 0, o_result = 0, o_err = 0, o_busy = 0.
  - Reset mid-operation abandons the computation. No o_valid pulse follows.
- States: IDLE, PREP, MONT, UPD, DONE.
- IDLE:
  - Accept happens when i_valid & o_ready. i_a, i_d, i_d_len and i_n are latched that cycle; the inputs are don't-care afterwards.
  - Error check on the latched values: i_n[0] == 0, i_n == 1, i_a ≥ i_n, or i_d_len > EXP_WIDTH. Any error sets o_err = 1, result = 0 and goes to DONE.
  - i_d_len == 0: result = 1 and go to DONE.
  - Otherwise go to PREP.
- PREP (exactly WIDTH cycles):
  - Starts with t = a. Each cycle: t ← (2t ≥ n) ? 2t − n : 2t, using a WIDTH+1-bit intermediate.
  - At exit, t = a·2^WIDTH mod n and m = 1. Bit index k = 0. Go to MONT.
- MONT (exactly WIDTH cycles, i = 0..WIDTH−1): both units step in parallel on a WIDTH+2-bit accumulator.
  - Square unit: operands (t, t).
  - Multiply unit: operands (t, m).
  - Step: acc ← (acc + x_i·y + q·n) >> 1, where q = parity of (acc + x_i·y).
  - On the last cycle, subtract n once if acc ≥ n, so the result is < n.
- UPD (1 cycle):
  - t ← square result.
  - If d[k] = 1: m ← multiply result; otherwise m is unchanged.
  - k ← k + 1. If k + 1 == len, latch result = m and go to DONE; else go to MONT.
- DONE:
  - o_valid = 1 with o_result and o_err stable.
  - On i_valid-side handshake i_ready = 1: go to IDLE next cycle and drop o_valid.
  - Input i_valid is ignored while not IDLE.
- Latency, accept cycle counted as cycle 0:
  - Normal run: o_valid first high at cycle 1 + WIDTH + len·(WIDTH+1).
  - Error or len = 0: o_valid first high at cycle 1.
- Back-to-back operation: a new accept is possible in the cycle after the result handshake, since IDLE is re-entered with o_ready = 1.
- Arithmetic invariants: all intermediates are < 2n < 2^(WIDTH+1). Never truncate below WIDTH+2 bits inside the Montgomery step.

Test Plan:
- WIDTH=8, a=5, d=3, len=2, n=33, i_ready=1 → o_valid at cycle 27, o_result=26, o_err=0.
- WIDTH=16, a=4, d=13, len=4, n=497 → o_valid at cycle 85, o_result=445. Repeat with d=0x800D, len=4 → same 445 (upper bits ignored).
- WIDTH=8, n=34 (even); then n=33 with a=40; then n=1 → each gives o_valid at cycle 1, o_err=1, o_result=0.
- WIDTH=8, len=0, a=7, n=33 → o_result=1 at cycle 1. Hold i_ready=0 for 10 cycles → o_valid and o_result stay stable, o_ready=0. New i_valid during this window is ignored.
- WIDTH=8, start a=5/d=3/n=33, assert i_rst at cycle 12 → next cycle o_busy=0, o_ready=1, o_valid never rises. Then run a=2, d=10, len=4, n=33 → o_result=1 (2^10 mod 33).
- WIDTH=256, random odd n, a<n, d, len=256 → matches the bench reference model. o_valid at cycle 1+256+256·257=66049. Two jobs run back-to-back with no idle gap beyond one cycle.
